// File: rtl/segment_select_ctrl.sv
// Sequencer for the segment selector: one-time seed load, then one selection per accepted request.
// Latency: result valid SEL_LATENCY+3 cycles after accept (2 cycles for a rejected request).
// Backpressure: one request in flight, out_req_ready only in IDLE; result held until in_ready. Option: SEG_SELECT_STATS_EN.
module segment_select_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SEL_LATENCY = 2
) (
    input  logic                    in_clock,
    input  logic                    in_reset_n,
    input  logic [WIDTH:0]          in_seed,
    input  logic                    in_req_valid,
    output logic                    out_req_ready,
    input  logic signed [WIDTH-1:0] in_c_less_than,
    input  logic signed [WIDTH-1:0] in_c_more_than,
    input  logic signed [WIDTH-1:0] in_min_variable,
    input  logic signed [WIDTH-1:0] in_max_variable,
    input  logic [1:0]              in_flag,
    output logic                    out_seg_reset,
    output logic                    out_seg_enable,
    output logic [WIDTH:0]          out_seg_seed,
    output logic signed [WIDTH-1:0] out_seg_c_less_than,
    output logic signed [WIDTH-1:0] out_seg_c_more_than,
    output logic signed [WIDTH-1:0] out_seg_min,
    output logic signed [WIDTH-1:0] out_seg_max,
    output logic [1:0]              out_seg_flag,
    input  logic [1:0]              in_seg_type,
    input  logic signed [WIDTH-1:0] in_seg_from,
    input  logic signed [WIDTH-1:0] in_seg_to,
    input  logic [WIDTH:0]          in_seg_weight,
    output logic                    out_valid,
    input  logic                    in_ready,
    output logic [1:0]              out_type,
    output logic signed [WIDTH-1:0] out_from,
    output logic signed [WIDTH-1:0] out_to,
    output logic [WIDTH:0]          out_weight,
    output logic                    out_error,
`ifdef SEG_SELECT_STATS_EN
    output logic [15:0]             out_cnt_uniform,
    output logic [15:0]             out_cnt_expup,
    output logic [15:0]             out_cnt_expdown,
    output logic [15:0]             out_cnt_error,
`endif
    output logic                    out_busy
);

    typedef enum logic [2:0] {
        S_SEED    = 3'd0,
        S_IDLE    = 3'd1,
        S_CHECK   = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT    = 3'd4,
        S_CAPTURE = 3'd5,
        S_HOLD    = 3'd6
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(SEL_LATENCY - 1);

    state_t     state_q;
    state_t     state_nxt;
    logic [3:0] cnt_q;
    logic       chk_err;
    logic       handoff;

    assign chk_err = (out_seg_flag == 2'd0) || (out_seg_min > out_seg_max);
    // out_valid only rises one cycle into HOLD, so HOLD always lasts at least two cycles
    assign handoff = (state_q == S_HOLD) && out_valid && in_ready;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= S_SEED;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_SEED:    state_nxt = S_IDLE;
            S_IDLE:    if (in_req_valid) state_nxt = S_CHECK;
            S_CHECK:   state_nxt = chk_err ? S_HOLD : S_ISSUE;
            S_ISSUE:   state_nxt = (SEL_LATENCY <= 1) ? S_CAPTURE : S_WAIT;
            S_WAIT:    if (cnt_q <= 4'd1) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_HOLD;
            S_HOLD:    if (handoff) state_nxt = S_IDLE;
            default:   state_nxt = S_SEED;
        endcase
    end

    always_comb begin
        out_req_ready = (state_q == S_IDLE);
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            cnt_q <= 4'd0;
        end else if (state_q == S_ISSUE) begin
            cnt_q <= LAT_M1;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Strobes are registered so that every output is quiet while reset is held;
    // the enable is looked ahead so it coincides with the ISSUE cycle.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            out_seg_reset       <= 1'b0;
            out_seg_enable      <= 1'b0;
            out_seg_seed        <= '0;
            out_seg_c_less_than <= '0;
            out_seg_c_more_than <= '0;
            out_seg_min         <= '0;
            out_seg_max         <= '0;
            out_seg_flag        <= 2'd0;
            out_valid           <= 1'b0;
            out_type            <= 2'd0;
            out_from            <= '0;
            out_to              <= '0;
            out_weight          <= '0;
            out_error           <= 1'b0;
            out_busy            <= 1'b0;
        end else begin
            out_seg_reset  <= (state_q == S_SEED);
            out_seg_enable <= (state_nxt == S_ISSUE);
            out_valid      <= (state_q == S_HOLD) && !handoff;
            out_busy       <= (state_nxt != S_IDLE);
            if (state_q == S_SEED) begin
                out_seg_seed <= in_seed;
            end
            if ((state_q == S_IDLE) && in_req_valid) begin
                out_seg_c_less_than <= in_c_less_than;
                out_seg_c_more_than <= in_c_more_than;
                out_seg_min         <= in_min_variable;
                out_seg_max         <= in_max_variable;
                out_seg_flag        <= in_flag;
            end
            if ((state_q == S_CHECK) && chk_err) begin
                out_type   <= 2'd0;
                out_from   <= '0;
                out_to     <= '0;
                out_weight <= '0;
                out_error  <= 1'b1;
            end else if (state_q == S_CAPTURE) begin
                out_type   <= in_seg_type;
                out_from   <= in_seg_from;
                out_to     <= in_seg_to;
                out_weight <= in_seg_weight;
                out_error  <= (in_seg_type == 2'd0);
            end
        end
    end

`ifdef SEG_SELECT_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            out_cnt_uniform <= 16'd0;
            out_cnt_expup   <= 16'd0;
            out_cnt_expdown <= 16'd0;
            out_cnt_error   <= 16'd0;
        end else if (handoff) begin
            if (out_error) begin
                out_cnt_error <= sat_inc(out_cnt_error);
            end else begin
                case (out_type)
                    2'd3:    out_cnt_uniform <= sat_inc(out_cnt_uniform);
                    2'd2:    out_cnt_expup   <= sat_inc(out_cnt_expup);
                    2'd1:    out_cnt_expdown <= sat_inc(out_cnt_expdown);
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_segment_select_ctrl.sv
// Randomized bench for segment_select_ctrl with a transaction-level model and a behavioural selector.
module tb_segment_select_ctrl;
    localparam int W = 32;
    localparam int L = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W:0]          seed    = '0;
    logic                req_vld = 1'b0;
    logic                req_rdy;
    logic signed [W-1:0] c_lt = '0, c_mt = '0, mn = '0, mx = '0;
    logic [1:0]          flag = 2'd0;
    logic                seg_rst, seg_en;
    logic [W:0]          seg_seed;
    logic signed [W-1:0] s_lt, s_mt, s_mn, s_mx;
    logic [1:0]          s_flag;
    logic [1:0]          sel_type = 2'd0;
    logic signed [W-1:0] sel_from = '0, sel_to = '0;
    logic [W:0]          sel_wt = '0;
    logic                vld, rdy = 1'b0, err, busy;
    logic [1:0]          typ;
    logic signed [W-1:0] from_v, to_v;
    logic [W:0]          wt;
`ifdef SEG_SELECT_STATS_EN
    logic [15:0] c_uni, c_up, c_dn, c_err;
    int e_uni = 0, e_up = 0, e_dn = 0, e_err = 0;
`endif

    segment_select_ctrl #(.WIDTH(W), .SEL_LATENCY(L)) dut (
        .in_clock(clk), .in_reset_n(rst_n), .in_seed(seed),
        .in_req_valid(req_vld), .out_req_ready(req_rdy),
        .in_c_less_than(c_lt), .in_c_more_than(c_mt),
        .in_min_variable(mn), .in_max_variable(mx), .in_flag(flag),
        .out_seg_reset(seg_rst), .out_seg_enable(seg_en), .out_seg_seed(seg_seed),
        .out_seg_c_less_than(s_lt), .out_seg_c_more_than(s_mt),
        .out_seg_min(s_mn), .out_seg_max(s_mx), .out_seg_flag(s_flag),
        .in_seg_type(sel_type), .in_seg_from(sel_from), .in_seg_to(sel_to),
        .in_seg_weight(sel_wt),
        .out_valid(vld), .in_ready(rdy), .out_type(typ), .out_from(from_v),
        .out_to(to_v), .out_weight(wt), .out_error(err),
`ifdef SEG_SELECT_STATS_EN
        .out_cnt_uniform(c_uni), .out_cnt_expup(c_up),
        .out_cnt_expdown(c_dn), .out_cnt_error(c_err),
`endif
        .out_busy(busy)
    );

    typedef struct {
        logic [1:0]          flag;
        logic signed [W-1:0] lt, mt, mn, mx;
        logic                bad_req;
        logic [1:0]          typ;
        logic signed [W-1:0] from_v, to_v;
        logic [W:0]          wt;
        logic                err;
        int                  acc_cyc;
        int                  n_en;
    } txn_t;

    txn_t q[$];
    int   total = 0, bad = 0, cyc = 0;
    int   rdy_mode = 0;
    bit   v_prev = 0, en_seen = 0, fixed_sel = 0;
    logic [99:0] snap = '0;
    logic [1:0]          res_type = 2'd0;
    logic signed [W-1:0] res_from = '0, res_to = '0;
    logic [W:0]          res_wt = '0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Selector stand-in: the chosen segment is on its outputs only in the cycle
    // SEL_LATENCY after the enable pulse; every other cycle carries junk.
    initial begin
        int since = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) since = 0;
            else if (en_seen) begin since = 1; en_seen = 0; end
            else if (since > 0 && since < 100) since++;
            if (since == L) begin
                sel_type = res_type; sel_from = res_from; sel_to = res_to; sel_wt = res_wt;
            end else begin
                sel_type = 2'($urandom_range(0, 3)); sel_from = $urandom; sel_to = $urandom;
                sel_wt = {1'($urandom_range(0, 1)), 32'($urandom)};
            end
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        txn_t t;
        cyc++;
        if (!rst_n) begin
            q.delete();
            v_prev  = 0;
            en_seen = 0;
`ifdef SEG_SELECT_STATS_EN
            e_uni = 0; e_up = 0; e_dn = 0; e_err = 0;
`endif
        end else begin
            if (vld) begin
                check("busy_in_hold", busy, 1);
                check("req_rdy_in_hold", req_rdy, 0);
                if (q.size() == 0) begin
                    check("spurious_valid", vld, 0);
                end else begin
                    if (!v_prev) check("latency", cyc - q[0].acc_cyc - 1, q[0].bad_req ? 2 : L + 3);
                    else check("hold_stable", {typ, from_v, to_v, wt, err}, snap);
                    snap = {typ, from_v, to_v, wt, err};
                    if (rdy) begin
                        t = q.pop_front();
                        check("result", {typ, from_v, to_v, wt, err}, {t.typ, t.from_v, t.to_v, t.wt, t.err});
                        check("enable_count", t.n_en, t.bad_req ? 0 : 1);
`ifdef SEG_SELECT_STATS_EN
                        if (t.err) e_err++;
                        else if (t.typ == 2'd3) e_uni++;
                        else if (t.typ == 2'd2) e_up++;
                        else if (t.typ == 2'd1) e_dn++;
`endif
                    end
                end
            end
            v_prev = vld && !rdy;
            if (seg_en) begin
                if (q.size() == 0) begin
                    check("spurious_enable", seg_en, 0);
                end else begin
                    q[0].n_en++;
                    check("operands", {s_flag, s_lt, s_mt, s_mn, s_mx},
                          {q[0].flag, q[0].lt, q[0].mt, q[0].mn, q[0].mx});
                    if (!fixed_sel) begin
                        res_type = 2'($urandom_range(0, 3)); res_from = $urandom; res_to = $urandom;
                        res_wt = {1'($urandom_range(0, 1)), 32'($urandom)};
                    end
                    q[0].typ = res_type; q[0].from_v = res_from; q[0].to_v = res_to;
                    q[0].wt = res_wt; q[0].err = (res_type == 2'd0);
                    en_seen = 1;
                end
            end
            if (req_vld && req_rdy) begin
                check("accept_while_busy", q.size(), 0);
                t.flag = flag; t.lt = c_lt; t.mt = c_mt; t.mn = mn; t.mx = mx;
                t.bad_req = (flag == 2'd0) || (mn > mx);
                t.typ = 2'd0; t.from_v = '0; t.to_v = '0; t.wt = '0; t.err = 1'b1;
                t.acc_cyc = cyc; t.n_en = 0;
                q.push_back(t);
            end
        end
    end

    // Entered at posedge+1 (or time 0); leaves at posedge+1.
    task automatic do_reset(input logic [W:0] s);
        int pulses = 0;
        rst_n = 1'b0; seed = s; req_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {vld, err, req_rdy, seg_rst, seg_en, busy}, 6'd0);
        check("rst_seed", seg_seed, 0);
        check("rst_result", {typ, from_v, to_v, wt}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (seg_rst) pulses++;
        end
        check("seed_pulses", pulses, 1);
        check("seed_value", seg_seed, s);
        check("idle_ready", req_rdy, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [1:0] f, input logic signed [W-1:0] lt, mt, a, b);
        bit done = 0;
        @(posedge clk);
        #1;
        flag = f; c_lt = lt; c_mt = mt; mn = a; mx = b; req_vld = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (req_rdy) done = 1;
        end
        if (!done) check("accept_timeout", req_rdy, 1);
        @(posedge clk);
        #1 req_vld = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] f;
        logic signed [W-1:0] a, b;
        do_reset(33'd5);

        fixed_sel = 1; res_type = 2'd3; res_from = 10; res_to = 20; res_wt = 33'd11;
        send_req(2'd3, 20, 10, 0, 100);
        drain();
        fixed_sel = 0;

        send_req(2'd0, 5, 6, 0, 100);    drain();
        send_req(2'd3, 1, 2, 50, 10);    drain();
        send_req(2'd1, 1, 2, -5, -5);    drain();
        send_req(2'd2, 1, 2, -10, 5);    drain();
        send_req(2'd3, 1, 2, 5, -10);    drain();

        rdy_mode = 2;
        send_req(2'd3, 7, 3, 0, 9);
        fork
            send_req(2'd2, 8, 4, 1, 2);
            begin
                repeat (16) @(posedge clk);
                #1 rdy_mode = 0;
            end
        join
        drain();

        send_req(2'd3, 4, 2, 0, 50);
        repeat (2) @(posedge clk);
        #1 check("busy_before_abort", {busy, vld}, 2'b10);
        do_reset(33'd9);
        send_req(2'd1, 3, 1, -100, 100);
        drain();

        for (int i = 0; i < 150; i++) begin
            rdy_mode = $urandom_range(0, 1);
            f = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            send_req(f, $urandom, $urandom, a, b);
            if ($urandom_range(0, 3) == 0) drain();
        end
        rdy_mode = 0;
        drain();

`ifdef SEG_SELECT_STATS_EN
        check("cnt_uniform", c_uni, e_uni);
        check("cnt_expup", c_up, e_up);
        check("cnt_expdown", c_dn, e_dn);
        check("cnt_error", c_err, e_err);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/segment_select_ctrl.md
Name: segment_select_ctrl

Overview:
- Sequencer in front of the per-variable segment selector (weighted random choice among up to three range segments).
- Accepts one selection request per variable from the sampler front end (bounds, constraint constants, flag) over valid/ready.
- Performs the one-time seed load, holds selector operands stable, and pulses the selector enable.
- Waits the fixed selector latency, then captures the chosen segment into a result register with valid/ready.

Parameters:
- WIDTH, 32: data width; weights are WIDTH+1 bits.
- SEL_LATENCY, 2: cycles from the selector-enable pulse to a valid selector output (1..15).

Ports:
- in_clock  in  1  system clock, rising edge.
- in_reset_n  in  1  asynchronous active-low reset.
- in_seed  in  WIDTH+1  seed value, nonzero; sampled in SEED.
- in_req_valid  in  1  request valid.
- out_req_ready  out  1  request accepted when high together with in_req_valid.
- in_c_less_than, in_c_more_than, in_min_variable, in_max_variable  in  WIDTH signed  request operands.
- in_flag  in  2  constraint kind: 1 = less-than only, 2 = greater-than only, 3 = both.
- out_seg_reset  out  1  seed-load strobe to the selector.
- out_seg_enable  out  1  one-cycle selection strobe to the selector.
- out_seg_seed  out  WIDTH+1  registered seed.
- out_seg_c_less_than, out_seg_c_more_than, out_seg_min, out_seg_max  out  WIDTH signed  latched operands.
- out_seg_flag  out  2  latched flag.
- in_seg_type  in  2  selector result type.
- in_seg_from, in_seg_to  in  WIDTH signed  selector result range.
- in_seg_weight  in  WIDTH+1  selector result weight.
- out_valid  out  1  result valid.
- in_ready  in  1  consumer ready.
- out_type  out  2  result type.
- out_from, out_to  out  WIDTH signed  result range.
- out_weight  out  WIDTH+1  result weight.
- out_error  out  1  result is an error response.
- out_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, in_reset_n=0):
  - State goes to SEED.
  - All outputs and registers are 0, including out_valid, out_error, out_req_ready and the strobes.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- FSM states: SEED, IDLE, CHECK, ISSUE, WAIT, CAPTURE, HOLD.
- SEED (first cycle after reset release):
  - Registers in_seed into out_seg_seed and asserts out_seg_reset for exactly 1 cycle.
  - Next state IDLE. The seed is never reloaded except through a reset.
- IDLE:
  - out_req_ready=1.
  - On in_req_valid, latch all operands into the out_seg_* registers and go to CHECK.
  - Latched operands stay constant until the next accept.
- CHECK (1 cycle), error when flag==0 or min>max (signed compare):
  - On error: out_type/from/to/weight=0, out_error=1, go to HOLD; no selector strobe is issued.
  - Otherwise go to ISSUE.
- ISSUE: out_seg_enable=1 for exactly 1 cycle; a 4-bit counter loads SEL_LATENCY-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle; at 0 go to CAPTURE.
  - Total from the ISSUE cycle to CAPTURE is SEL_LATENCY cycles.
- CAPTURE:
  - Register in_seg_type/from/to/weight into the out_* registers.
  - out_error=1 when in_seg_type==0 (no segment chosen); otherwise out_error=0.
  - Go to HOLD.
- HOLD:
  - out_valid=1; the result is stable while in_ready=0.
  - On in_ready, drop out_valid next cycle and return to IDLE.
- Timing:
  - Minimum request-to-valid latency for a legal request is SEL_LATENCY+3 cycles after the accept edge.
  - Back-to-back throughput is one request per SEL_LATENCY+5 cycles.
- out_req_ready=0 in every state except IDLE. A request held valid during busy is accepted at the next IDLE.
- in_ready=1 and in_req_valid=1 together in HOLD: only the result completes that cycle; the request is accepted in the following IDLE cycle.
- No arithmetic on the data path; all values pass through with width unchanged, signed.

Optional Feature:
- Macro SEG_SELECT_STATS_EN.
- Defined:
  - Adds output ports out_cnt_uniform, out_cnt_expup, out_cnt_expdown and out_cnt_error (16 bits each).
  - A counter increments when a result of type 3, 2 or 1 (or an error) is handed off in HOLD with in_ready.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release with in_seed=33'd5 -> out_seg_reset high for exactly 1 cycle, out_seg_seed=5, then out_req_ready=1.
- Request flag=3, c_more=10, c_less=20, min=0, max=100, selector model returns type=3 from=10 to=20 weight=11, SEL_LATENCY=2 -> single out_seg_enable pulse, out_valid 5 cycles after accept with exactly those values, out_error=0.
- Request flag=0 -> out_valid with out_error=1, all fields 0, out_seg_enable never asserted.
- Request min=50, max=10 -> same error response as flag=0.
- Hold in_ready=0 for 10 cycles -> result stable, out_req_ready=0 throughout; second pending request accepted only after the handoff.
- Assert in_reset_n=0 during WAIT -> out_valid stays 0, FSM reseeds; a new request then completes normally.
